// File: rtl/accum_sched.sv
// Two-requester burst accumulator: round-robin grant, per-burst signed sum
// with optional saturation, result held until the consumer accepts it.
module accum_sched #(
    parameter int unsigned DATA_W = 16,
    parameter bit          SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        cfg_len,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    output logic              res_ovf,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        count_q, count_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              any_req;
    logic              grant_id;
    logic              owner_valid;
    logic [DATA_W-1:0] owner_data;
    logic [7:0]        count_inc;
    logic              xfer;
    logic              last_word;
    logic              handshake;
    logic [DATA_W:0]   sum_ext;
    logic              sum_ovf;
    logic [DATA_W-1:0] sum_res;

    assign any_req     = req0_valid | req1_valid;
    // On a tie the requester not served last wins; last_q resets to 1 so req0 wins first.
    assign grant_id    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign owner_valid = owner_q ? req1_valid : req0_valid;
    assign owner_data  = owner_q ? req1_data : req0_data;
    assign count_inc   = count_q + 8'd1;
    assign xfer        = (state_q == StAccum) && owner_valid;
    assign last_word   = xfer && (count_inc == len_q);
    assign handshake   = (state_q == StHold) && res_ready;

    // One guard bit exposes signed overflow as a mismatch of the top two bits.
    assign sum_ext = {acc_q[DATA_W-1], acc_q} + {owner_data[DATA_W-1], owner_data};
    assign sum_ovf = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];

    always_comb begin
        sum_res = sum_ext[DATA_W-1:0];
        if (SAT && sum_ovf) begin
            sum_res = sum_ext[DATA_W] ? MinVal : MaxVal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            len_q   <= 8'd1;
            count_q <= 8'd0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req)   state_d = StAccum;
            StAccum: if (last_word) state_d = StHold;
            StHold:  if (handshake) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if ((state_q == StIdle) && any_req) begin
            owner_d = grant_id;
            len_d   = (cfg_len == 8'd0) ? 8'd1 : cfg_len;
            count_d = 8'd0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end
        if (xfer) begin
            acc_d   = sum_res;
            count_d = count_inc;
            ovf_d   = ovf_q | sum_ovf;
        end
        if (handshake) begin
            last_d = owner_q;
        end
    end

    always_comb begin
        req0_ready = (state_q == StAccum) && !owner_q;
        req1_ready = (state_q == StAccum) && owner_q;
        busy       = (state_q != StIdle);
        res_valid  = (state_q == StHold);
        res_data   = (state_q == StHold) ? acc_q : '0;
        res_id     = (state_q == StHold) && owner_q;
        res_ovf    = (state_q == StHold) && ovf_q;
    end

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched: saturating and wrapping instances share
// stimulus; an integer-arithmetic burst model is compared every cycle.
module tb_accum_sched;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        res_ready;

    logic        s_r0, s_r1, s_rv, s_id, s_ovf, s_busy;
    logic [15:0] s_data;
    logic        w_r0, w_r1, w_rv, w_id, w_ovf, w_busy;
    logic [15:0] w_data;

    int n_pass  = 0;
    int n_total = 0;

    accum_sched #(.DATA_W(16), .SAT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
        .res_valid(s_rv), .res_data(s_data), .res_id(s_id), .res_ovf(s_ovf),
        .res_ready(res_ready), .busy(s_busy)
    );

    accum_sched #(.DATA_W(16), .SAT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(w_r0),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(w_r1),
        .res_valid(w_rv), .res_data(w_data), .res_id(w_id), .res_ovf(w_ovf),
        .res_ready(res_ready), .busy(w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Burst model: index 0 saturates, index 1 wraps.
    bit m_busy, m_done, m_owner, m_last;
    int m_len, m_cnt;
    int m_sum [2];
    bit m_ovf [2];

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_owner = 0; m_last = 1;
        m_len = 1; m_cnt = 0;
        m_sum[0] = 0; m_sum[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    endtask

    task automatic model_step();
        int d, s;
        if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_owner = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
                m_cnt = 0;
                m_sum[0] = 0; m_sum[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
                m_busy = 1;
            end
        end else if (!m_done) begin
            if (m_owner ? req1_valid : req0_valid) begin
                d = m_owner ? int'($signed(req1_data)) : int'($signed(req0_data));
                for (int k = 0; k < 2; k++) begin
                    s = m_sum[k] + d;
                    if (s > 32767 || s < -32768) m_ovf[k] = 1;
                    if (k == 0) begin
                        if (s > 32767) s = 32767;
                        if (s < -32768) s = -32768;
                    end else begin
                        if (s > 32767) s = s - 65536;
                        if (s < -32768) s = s + 65536;
                    end
                    m_sum[k] = s;
                end
                m_cnt++;
                if (m_cnt == m_len) m_done = 1;
            end
        end else if (res_ready) begin
            m_busy = 0; m_done = 0; m_last = m_owner;
        end
    endtask

    always @(negedge clk) begin
        int hold;
        if (!rst_n) model_reset();
        hold = m_busy && m_done;
        chk("s_ready0", s_r0, m_busy && !m_done && !m_owner);
        chk("s_ready1", s_r1, m_busy && !m_done && m_owner);
        chk("s_busy", s_busy, m_busy);
        chk("s_res_valid", s_rv, hold);
        chk("s_res_data", int'($signed(s_data)), hold ? m_sum[0] : 0);
        chk("s_res_id", s_id, hold && m_owner);
        chk("s_res_ovf", s_ovf, hold && m_ovf[0]);
        chk("w_ready0", w_r0, m_busy && !m_done && !m_owner);
        chk("w_ready1", w_r1, m_busy && !m_done && m_owner);
        chk("w_res_valid", w_rv, hold);
        chk("w_res_data", int'($signed(w_data)), hold ? m_sum[1] : 0);
        chk("w_res_ovf", w_ovf, hold && m_ovf[1]);
        if (rst_n) model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int who, input int len, input int n, input int w [4]);
        cfg_len = 8'(len);
        if (who == 0) begin req0_valid = 1; req0_data = 16'(w[0]); end
        else begin req1_valid = 1; req1_data = 16'(w[0]); end
        step();  // grant cycle
        for (int i = 0; i < n; i++) begin
            if (who == 0) req0_data = 16'(w[i]);
            else req1_data = 16'(w[i]);
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic ack();
        res_ready = 1;
        step();
        res_ready = 0;
    endtask

    int q_id[$];
    int q_data[$];
    int exp_id [3] = '{0, 1, 0};
    int exp_dt [3] = '{2, 200, 2};

    initial begin
        rst_n = 0; cfg_len = 0; res_ready = 0;
        req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
        step(); step();
        rst_n = 1;

        // Round-robin under continuous contention
        cfg_len = 2; req0_valid = 1; req1_valid = 1;
        req0_data = 1; req1_data = 100; res_ready = 1;
        for (int i = 0; i < 20 && q_id.size() < 3; i++) begin
            step();
            if (s_rv) begin q_id.push_back(int'(s_id)); q_data.push_back(int'(s_data)); end
        end
        req0_valid = 0; req1_valid = 0;
        step();
        res_ready = 0;
        chk("rr_results", q_id.size(), 3);
        for (int i = 0; i < q_id.size() && i < 3; i++) begin
            chk("rr_id", q_id[i], exp_id[i]);
            chk("rr_data", q_data[i], exp_dt[i]);
        end
        step();

        // 1+2+3+4 back-to-back
        burst(0, 4, 4, '{1, 2, 3, 4});
        chk("b4_valid", s_rv, 1);
        chk("b4_data", int'(s_data), 10);
        chk("b4_id", s_id, 0);
        chk("b4_ovf", s_ovf, 0);
        ack();

        // Positive overflow: clamp vs wrap
        burst(0, 2, 2, '{'h7000, 'h2000, 0, 0});
        chk("sat_pos_data", int'(s_data), 'h7FFF);
        chk("sat_pos_ovf", s_ovf, 1);
        chk("wrap_pos_data", int'(w_data), 'h9000);
        chk("wrap_pos_ovf", w_ovf, 1);
        ack();

        // Accumulation continues from the clamped value
        burst(1, 3, 3, '{'h7000, 'h2000, -1, 0});
        chk("sat_cont_data", int'(s_data), 'h7FFE);
        chk("wrap_cont_data", int'(w_data), 'h8FFF);
        chk("sat_cont_id", s_id, 1);
        ack();

        // Negative overflow
        burst(0, 2, 2, '{-32768, -1, 0, 0});
        chk("sat_neg_data", int'(s_data), 'h8000);
        chk("wrap_neg_data", int'(w_data), 'h7FFF);
        chk("wrap_neg_ovf", w_ovf, 1);
        ack();

        // Owner gaps, stray res_ready and cfg_len change during the burst
        cfg_len = 3; req0_valid = 1; req0_data = 5;
        step();
        req0_valid = 0; res_ready = 1;
        step();
        req0_valid = 1; cfg_len = 7;
        step();
        req0_valid = 0;
        step(); step();
        req0_valid = 1; req0_data = 6;
        step();
        req0_valid = 0;
        step();
        req0_valid = 1; req0_data = 7; res_ready = 0;
        step();
        req0_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", s_rv, 1);
            chk("hold_data", int'(s_data), 18);
            chk("hold_id", s_id, 0);
            step();
        end
        ack();
        chk("idle_busy", s_busy, 0);
        chk("idle_valid", s_rv, 0);

        // cfg_len = 0 behaves as a single-word burst
        burst(1, 0, 1, '{5, 0, 0, 0});
        chk("len0_valid", s_rv, 1);
        chk("len0_data", int'(s_data), 5);
        chk("len0_id", s_id, 1);
        ack();

        // Asynchronous reset mid-burst
        cfg_len = 4; req0_valid = 1; req0_data = 9;
        step(); step(); step();
        #1 rst_n = 0;
        #1;
        chk("rst_busy", s_busy, 0);
        chk("rst_ready0", s_r0, 0);
        chk("rst_valid", s_rv, 0);
        chk("rst_data", int'(s_data), 0);
        chk("rst_id", s_id, 0);
        chk("rst_ovf", s_ovf, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1; req0_valid = 0;
        burst(0, 2, 2, '{3, 4, 0, 0});
        chk("post_rst_data", int'(s_data), 7);
        chk("post_rst_ovf", s_ovf, 0);
        ack();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data/accumulator width (signed two's complement).
REQ-002 SHALL have parameter SAT, default 1, meaning 1 = saturating accumulate and 0 = wrap-around accumulate.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cfg_len  input  8  words per burst; sampled only at grant; 0 treated as 1.
REQ-007 SHALL have ports req0_valid / req1_valid  input  1  requester has a data word.
REQ-008 SHALL have ports req0_data / req1_data  input  DATA_W  requester data word.
REQ-009 SHALL have ports req0_ready / req1_ready  output  1  word accepted when valid and ready are both high.
REQ-010 SHALL have port res_valid  output  1  burst result available.
REQ-011 SHALL have port res_data  output  DATA_W  accumulated burst sum.
REQ-012 SHALL have port res_id  output  1  requester that owns res_data.
REQ-013 SHALL have port res_ovf  output  1  overflow occurred during the burst.
REQ-014 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-017 IDLE: with any reqN_valid high, SHALL grant in that cycle, go to ACCUM next cycle, latch owner and len=max(cfg_len,1), clear the accumulator, the count and ovf.
REQ-018 Arbitration SHALL be round-robin: when both requesters are valid, the grant goes to the requester not served last; after reset, req0 wins the first tie.
REQ-019 Both readys SHALL be 0 in IDLE and HOLD; in ACCUM only the owner's ready SHALL be 1; the non-owner's ready SHALL stay 0.
REQ-020 ACCUM: each transfer SHALL add the owner's data to acc and increment count; cycles with owner valid low SHALL stall with no change.
REQ-021 The transfer that makes count equal len SHALL move the FSM to HOLD, with res_valid=1 and res_data equal to the final sum on the next cycle (1-cycle latency from last word).
REQ-022 SAT=1: a sum above max or below min SHALL clamp to 0x7FFF / 0x8000 (DATA_W=16) and set ovf; later words continue from the clamped value.
REQ-023 SAT=0: the sum SHALL wrap mod 2^DATA_W, and ovf SHALL still set on signed overflow.
REQ-024 HOLD: res_valid, res_data, res_id and res_ovf SHALL stay stable until res_ready=1.
REQ-025 On the res_ready handshake, the FSM SHALL return to IDLE next cycle, the round-robin pointer SHALL record the owner, and res_valid SHALL drop.
REQ-026 No new grant SHALL occur in the HOLD handshake cycle; the earliest re-grant is the cycle after entering IDLE.
REQ-027 A change of cfg_len during ACCUM/HOLD SHALL not affect the current burst.
REQ-028 A res_ready asserted outside HOLD SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, acc=0, count=0, readys=0, res_valid=0, res_data=0, res_id=0, res_ovf=0, busy=0, RR pointer favouring req0.
REQ-030 Reset mid-burst SHALL discard the partial sum; no result SHALL be produced for it.

Verification
REQ-031 cfg_len=4, req0 sends 1,2,3,4 back-to-back -> res_valid 1 cycle after last word, res_data=10, res_id=0, res_ovf=0.
REQ-032 Both valid continuously, cfg_len=2 -> grants alternate req0, req1, req0; the non-owner's ready is never high.
REQ-033 SAT=1, cfg_len=2, data 0x7000 and 0x2000 -> res_data=0x7FFF, res_ovf=1; SAT=0 with the same data -> 0x9000, res_ovf=1.
REQ-034 cfg_len=3 with owner valid gaps and res_ready held low 5 cycles -> sum correct, result stable through HOLD, IDLE one cycle after handshake.
REQ-035 cfg_len=0 -> single-word burst; asynchronous rst_n pulse mid-ACCUM -> all outputs 0 immediately, next burst sums from 0.
